// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: front-panel controller that loads A/B operands and an opcode, issues the ALU operation and flags valid results.
// Ports:
//   clk, reset (async, active-low)
//   sw_data            operand switches
//   btn_enter_n        enter/next button (active-low, async)
//   btn_mode_n         mode-cycle button (active-low, async)
//   btn_clear_n        clear/abort button (active-low, async)
//   op_btn_n[3:0]      opcode buttons (active-low, async)
//   A_num, B_num       operands to datapath
//   operations_buttons active-low one-hot opcode, 4'b1111 = none
//   change_mode        ALU mode/group select
//   alu_start          one-cycle issue pulse
//   result_valid       display registers valid
//   state_code         FSM state for LEDs
// Build option: define DEBOUNCE_EN to insert a DB_CYCLES stability filter on every button.
module alu_op_sequencer #(
  parameter int N         = 2,
  parameter int ALU_LAT   = 2,
  parameter int DB_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] sw_data,
  input  logic         btn_enter_n,
  input  logic         btn_mode_n,
  input  logic         btn_clear_n,
  input  logic [3:0]   op_btn_n,
  output logic [N-1:0] A_num,
  output logic [N-1:0] B_num,
  output logic [3:0]   operations_buttons,
  output logic [1:0]   change_mode,
  output logic         alu_start,
  output logic         result_valid,
  output logic [2:0]   state_code
);
  localparam int CW = $clog2(ALU_LAT + 1);
  if (ALU_LAT < 1 || DB_CYCLES < 1) begin : g_param_chk
    $error("alu_op_sequencer: ALU_LAT and DB_CYCLES must be >= 1");
  end
  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    ISSUE  = 3'd3,
    WAIT   = 3'd4,
    SHOW   = 3'd5
  } state_t;
  state_t state, state_n;
  // Button bit order: {op[3:0], clear, mode, enter}; idle level is 1 so reset leaves no pending press.
  logic [6:0] s1, s2, lvl, lvl_d, press;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1    <= '1;
      s2    <= '1;
      lvl_d <= '1;
    end else begin
      s1    <= {op_btn_n, btn_clear_n, btn_mode_n, btn_enter_n};
      s2    <= s1;
      lvl_d <= lvl;
    end
`ifdef DEBOUNCE_EN
  localparam int DW = $clog2(DB_CYCLES + 1);
  logic [6:0]    db;
  logic [DW-1:0] db_cnt [7];
  // The debounced level only follows s2 after DB_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      db <= '1;
      for (int j = 0; j < 7; j++) db_cnt[j] <= '0;
    end else begin
      for (int j = 0; j < 7; j++)
        if (s2[j] == db[j]) db_cnt[j] <= '0;
        else if (db_cnt[j] == DW'(DB_CYCLES - 1)) begin
          db[j]     <= s2[j];
          db_cnt[j] <= '0;
        end else db_cnt[j] <= db_cnt[j] + 1'b1;
    end
  assign lvl = db;
`else
  assign lvl = s2;
`endif
  assign press = lvl_d & ~lvl;
  logic       clr_p, ent_p, op_p, mode_p;
  logic [1:0] op_idx;
  assign clr_p  = press[2];
  assign ent_p  = press[0] & ~clr_p;
  assign op_p   = |press[6:3] & ~clr_p & ~ent_p;
  assign mode_p = press[1] & ~clr_p & ~ent_p & ~op_p;
  assign op_idx = press[3] ? 2'd0 : press[4] ? 2'd1 : press[5] ? 2'd2 : 2'd3;
  logic [N-1:0]  a_n, b_n;
  logic [3:0]    ops_n;
  logic [1:0]    mode_n, op_sel, sel_n;
  logic          op_vld, vld_n;
  logic [CW-1:0] cnt, cnt_n;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state              <= GET_A;
      A_num              <= '0;
      B_num              <= '0;
      operations_buttons <= 4'b1111;
      change_mode        <= '0;
      op_sel             <= '0;
      op_vld             <= 1'b0;
      cnt                <= '0;
    end else begin
      state              <= state_n;
      A_num              <= a_n;
      B_num              <= b_n;
      operations_buttons <= ops_n;
      change_mode        <= mode_n;
      op_sel             <= sel_n;
      op_vld             <= vld_n;
      cnt                <= cnt_n;
    end
  always_comb begin
    state_n = state;
    a_n     = A_num;
    b_n     = B_num;
    ops_n   = operations_buttons;
    sel_n   = op_sel;
    vld_n   = op_vld;
    cnt_n   = cnt;
    mode_n  = change_mode;
    if (clr_p) begin
      state_n = GET_A;
      a_n     = '0;
      b_n     = '0;
      ops_n   = 4'b1111;
      vld_n   = 1'b0;
    end else begin
      case (state)
        GET_A: if (ent_p) begin
          a_n     = sw_data;
          state_n = GET_B;
        end
        GET_B: if (ent_p) begin
          b_n     = sw_data;
          state_n = GET_OP;
        end
        GET_OP: begin
          state_n = ent_p && op_vld ? ISSUE : GET_OP;
          if (op_p) begin
            sel_n = op_idx;
            vld_n = 1'b1;
          end
        end
        ISSUE: begin
          ops_n   = ~(4'b0001 << op_sel);
          cnt_n   = '0;
          state_n = WAIT;
        end
        WAIT: begin
          state_n = cnt == CW'(ALU_LAT - 1) ? SHOW : WAIT;
          cnt_n   = cnt + 1'b1;
        end
        SHOW: state_n = ent_p ? GET_A : mode_p ? GET_OP : SHOW;
        default: state_n = GET_A;
      endcase
      // Mode is frozen while an operation is in flight.
      if (mode_p && state != ISSUE && state != WAIT) mode_n = change_mode + 1'b1;
    end
  end
  assign alu_start    = state == ISSUE;
  assign result_valid = state == SHOW;
  assign state_code   = state;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed self-checking bench for alu_op_sequencer.
module tb_alu_op_sequencer;
  localparam int N  = 2;
  localparam int DB = 16;
`ifdef DEBOUNCE_EN
  localparam int HOLD = DB + 4;
  localparam int POST = DB + 4;
`else
  localparam int HOLD = 2;
  localparam int POST = 2;
`endif
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] sw_data = '0;
  logic         btn_enter_n = 1'b1;
  logic         btn_mode_n = 1'b1;
  logic         btn_clear_n = 1'b1;
  logic [3:0]   op_btn_n = 4'hf;
  logic [N-1:0] A_num, B_num;
  logic [3:0]   operations_buttons;
  logic [1:0]   change_mode;
  logic         alu_start, result_valid;
  logic [2:0]   state_code;
  int errors = 0;
  int checks = 0;
  int starts = 0;
  alu_op_sequencer #(.N(N), .ALU_LAT(2), .DB_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .sw_data(sw_data),
    .btn_enter_n(btn_enter_n), .btn_mode_n(btn_mode_n), .btn_clear_n(btn_clear_n),
    .op_btn_n(op_btn_n), .A_num(A_num), .B_num(B_num),
    .operations_buttons(operations_buttons), .change_mode(change_mode),
    .alu_start(alu_start), .result_valid(result_valid), .state_code(state_code)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (alu_start) starts++;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic press(input logic en, input logic md, input logic cl, input logic [3:0] op);
    btn_enter_n = ~en;
    btn_mode_n  = ~md;
    btn_clear_n = ~cl;
    op_btn_n    = ~op;
    tick(HOLD);
    btn_enter_n = 1'b1;
    btn_mode_n  = 1'b1;
    btn_clear_n = 1'b1;
    op_btn_n    = 4'hf;
    tick(POST);
  endtask
  // extra: 0 plain issue, 1 mode press landing in WAIT, 2 clear press landing in WAIT
  task automatic enter_issue(input int extra, input logic [N-1:0] ea, input logic [N-1:0] eb, input logic [3:0] eops);
    int k;
    btn_enter_n = 1'b0;
    tick(2);
    if (extra == 1) btn_mode_n = 1'b0;
    if (extra == 2) btn_clear_n = 1'b0;
    k = 0;
    do begin
      tick(1);
      k++;
    end while (!alu_start && k < 40);
    chk("alu_start_rise", alu_start, 1);
    chk("issue_state", state_code, 3);
    chk("issue_a", A_num, ea);
    chk("issue_b", B_num, eb);
    chk("issue_rv", result_valid, 0);
    tick(1);
    chk("wait_ops", operations_buttons, eops);
    chk("alu_start_fall", alu_start, 0);
    chk("wait1_rv", result_valid, 0);
    tick(1);
    if (extra == 2) begin
      chk("clr_state", state_code, 0);
      chk("clr_ops", operations_buttons, 4'hf);
      chk("clr_a", A_num, 0);
      chk("clr_b", B_num, 0);
      for (int i = 0; i < 5; i++) begin
        tick(1);
        chk("clr_rv_low", result_valid, 0);
      end
    end else begin
      chk("wait2_rv", result_valid, 0);
      chk("wait2_state", state_code, 4);
      tick(1);
      chk("show_rv", result_valid, 1);
      chk("show_state", state_code, 5);
      chk("show_ops", operations_buttons, eops);
    end
    btn_enter_n = 1'b1;
    btn_mode_n  = 1'b1;
    btn_clear_n = 1'b1;
    tick(POST);
  endtask
  initial begin
    tick(3);
    chk("rst_state", state_code, 0);
    chk("rst_a", A_num, 0);
    chk("rst_b", B_num, 0);
    chk("rst_ops", operations_buttons, 4'hf);
    chk("rst_mode", change_mode, 0);
    chk("rst_start", alu_start, 0);
    chk("rst_rv", result_valid, 0);
    reset = 1'b1;
    tick(2);
    sw_data = 2'b11;
    press(1, 0, 0, 0);
    chk("t1_a_state", state_code, 1);
    chk("t1_a", A_num, 3);
    sw_data = 2'b01;
    press(1, 0, 0, 0);
    chk("t1_b_state", state_code, 2);
    chk("t1_b", B_num, 1);
    press(1, 0, 0, 0);
    chk("t2_state", state_code, 2);
    chk("t2_starts", starts, 0);
    press(0, 0, 0, 4'b0001);
    chk("t1_op_state", state_code, 2);
    enter_issue(0, 2'd3, 2'd1, 4'b1110);
    chk("t1_starts", starts, 1);
    press(1, 0, 0, 0);
    chk("show_exit_state", state_code, 0);
    chk("show_exit_rv", result_valid, 0);
    chk("held_ops", operations_buttons, 4'b1110);
    repeat (5) press(0, 1, 0, 0);
    chk("t3_mode5", change_mode, 1);
    sw_data = 2'b10;
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    chk("t3_getop", state_code, 2);
    enter_issue(1, 2'd2, 2'd2, 4'b1110);
    chk("t3_mode_wait", change_mode, 1);
    press(0, 1, 0, 0);
    chk("show_mode_state", state_code, 2);
    chk("show_mode_rv", result_valid, 0);
    chk("show_mode_val", change_mode, 2);
    enter_issue(2, 2'd2, 2'd2, 4'b1110);
    chk("t4_mode_kept", change_mode, 2);
    sw_data = 2'b01;
    press(1, 0, 0, 0);
    sw_data = 2'b10;
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    chk("t5_no_op_state", state_code, 2);
    press(0, 0, 0, 4'b1010);
    enter_issue(0, 2'd1, 2'd2, 4'b1101);
    press(1, 0, 0, 0);
    sw_data = 2'b11;
    press(1, 0, 0, 0);
    chk("t5_pre_state", state_code, 1);
    chk("t5_pre_a", A_num, 3);
    press(1, 0, 1, 0);
    chk("t5_clr_state", state_code, 0);
    chk("t5_clr_a", A_num, 0);
    chk("t5_clr_ops", operations_buttons, 4'hf);
`ifdef DEBOUNCE_EN
    btn_enter_n = 1'b0;
    tick(5);
    btn_enter_n = 1'b1;
    tick(30);
    chk("t6_glitch_state", state_code, 0);
    btn_enter_n = 1'b0;
    tick(20);
    btn_enter_n = 1'b1;
    tick(30);
    chk("t6_press_state", state_code, 1);
`endif
    sw_data = 2'b10;
    press(1, 0, 0, 0);
    chk("rst_mid_pre", A_num, 2);
    reset = 1'b0;
    tick(1);
    chk("rst_mid_state", state_code, 0);
    chk("rst_mid_a", A_num, 0);
    chk("rst_mid_mode", change_mode, 0);
    reset = 1'b1;
    tick(POST + 4);
    chk("rst_mid_idle", state_code, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
